imem_program_loader: RTL and testbench

- Writer side of the instruction memory.
- Receives a framed byte stream from the debug UART receiver, assembles big-endian 32-bit instruction words and writes them sequentially into the instruction memory write port starting at address 0.
- While loading, it holds the fetch stage frozen by driving PC write-enable low. On a successful load it pulses a PC clear and releases the CPU.

---
 rtl/imem_program_loader_pkg.sv | 22 ++
 rtl/imem_program_loader_word_assembler.sv | 34 +++
 rtl/imem_program_loader.sv | 157 +++++++++++++++
 tb/tb_imem_program_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: frame marker,
// loader state encoding and memory depth helper.
package imem_program_loader_pkg;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // Word capacity of the instruction memory; 17 bits so a full 16-bit address space still fits.
    function automatic logic [16:0] mem_depth(input int unsigned addr_b);
        return 17'(1) << addr_b;
    endfunction

endpackage

// File: rtl/imem_program_loader_word_assembler.sv
// Byte-to-word assembler for the program loader: shifts payload bytes in
// big-endian order, tracks byte position and the running XOR checksum.
module loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        capture,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_ready,
    output logic [7:0]  checksum
);

    logic [23:0] shreg;
    logic [1:0]  byte_cnt;

    // The completed word includes the byte being captured this cycle, so the
    // owner can register it on the same edge.
    assign word       = {shreg, data};
    assign word_ready = capture && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shreg    <= '0;
            byte_cnt <= '0;
            checksum <= '0;
        end else if (capture) begin
            shreg    <= {shreg[15:0], data};
            byte_cnt <= byte_cnt + 2'd1;
            checksum <= checksum ^ data;
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// Instruction-memory writer: parses framed bytes from the debug UART, writes
// assembled words from address 0 and holds the fetch stage while loading.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int         width_B  = 32,
    parameter int         Addr_B   = 10,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                mem_we,
    output logic [Addr_B-1:0]   mem_addr,
    output logic [width_B-1:0]  mem_wdata,
    output logic                pc_write,
    output logic                pc_clear,
    output logic                loading,
    output logic                load_done,
    output logic                load_error
);

    localparam logic [16:0] DEPTH = mem_depth(Addr_B);

    state_t state, state_next;
    logic [15:0] length, length_next;
    logic [16:0] word_cnt, word_cnt_next;

    logic               mem_we_next;
    logic [Addr_B-1:0]  mem_addr_next;
    logic [width_B-1:0] mem_wdata_next;
    logic pc_write_next, pc_clear_next, loading_next, load_done_next, load_error_next;

    logic        asm_clear, asm_capture, word_ready;
    logic [31:0] word;
    logic [7:0]  checksum;

    loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .capture    (asm_capture),
        .data       (rx_data),
        .word       (word),
        .word_ready (word_ready),
        .checksum   (checksum)
    );

    always_comb begin
        state_next      = state;
        length_next     = length;
        word_cnt_next   = word_cnt;
        mem_we_next     = 1'b0;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;
        pc_write_next   = pc_write;
        pc_clear_next   = 1'b0;
        loading_next    = loading;
        load_done_next  = load_done;
        load_error_next = load_error;
        asm_clear       = 1'b0;
        asm_capture     = 1'b0;

        case (state)
            // DONE lasts one cycle but, like ERROR, already accepts a new header.
            IDLE, DONE, ERROR: begin
                if (state == DONE) state_next = IDLE;
                if (rx_valid && rx_data == HDR_BYTE) begin
                    state_next      = LEN_HI;
                    loading_next    = 1'b1;
                    pc_write_next   = 1'b0;
                    load_done_next  = 1'b0;
                    load_error_next = 1'b0;
                    asm_clear       = 1'b1;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    length_next[15:8] = rx_data;
                    state_next        = LEN_LO;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    length_next   = {length[15:8], rx_data};
                    word_cnt_next = '0;
                    if ({1'b0, length_next} > DEPTH) begin
                        state_next      = ERROR;
                        loading_next    = 1'b0;
                        load_error_next = 1'b1;
                        pc_write_next   = 1'b0;
                    end else if (length_next == 16'd0) begin
                        state_next = CHECK;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                asm_capture = rx_valid;
                if (word_ready) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = word_cnt[Addr_B-1:0];
                    mem_wdata_next = word;
                    word_cnt_next  = word_cnt + 17'd1;
                    if (word_cnt_next == {1'b0, length}) state_next = CHECK;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    loading_next = 1'b0;
                    if (rx_data == checksum) begin
                        state_next     = DONE;
                        pc_clear_next  = 1'b1;
                        load_done_next = 1'b1;
                        pc_write_next  = 1'b1;
                    end else begin
                        state_next      = ERROR;
                        load_error_next = 1'b1;
                        pc_write_next   = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            length     <= '0;
            word_cnt   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pc_write   <= 1'b1;
            pc_clear   <= 1'b0;
            loading    <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state      <= state_next;
            length     <= length_next;
            word_cnt   <= word_cnt_next;
            mem_we     <= mem_we_next;
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
            pc_write   <= pc_write_next;
            pc_clear   <= pc_clear_next;
            loading    <= loading_next;
            load_done  <= load_done_next;
            load_error <= load_error_next;
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: frame-position reference model
// compared every cycle, plus literal expectations for the directed frames.
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        pc_write, pc_clear, loading, load_done, load_error;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    imem_program_loader #(
        .width_B  (32),
        .Addr_B   (10),
        .HDR_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .pc_write   (pc_write),
        .pc_clear   (pc_clear),
        .loading    (loading),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: tracks position within the frame and derives outputs from frame rules.
    bit          m_active;
    int          m_pos;
    int          m_n;
    logic [7:0]  m_chk;
    logic [31:0] m_word;
    logic        e_we, e_pcw, e_pcc, e_load, e_done, e_err;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata;

    always @(posedge clk) begin
        e_we  = 1'b0;
        e_pcc = 1'b0;
        if (reset) begin
            m_active = 0; e_addr = '0; e_wdata = '0;
            e_pcw = 1; e_load = 0; e_done = 0; e_err = 0;
        end else if (rx_valid) begin
            if (!m_active) begin
                if (rx_data == 8'hA5) begin
                    m_active = 1; m_pos = 0; m_chk = '0; m_n = 0;
                    e_load = 1; e_pcw = 0; e_done = 0; e_err = 0;
                end
            end else begin
                if (m_pos == 0) begin
                    m_n = int'(rx_data) * 256;
                end else if (m_pos == 1) begin
                    m_n = m_n + int'(rx_data);
                    if (m_n > 1024) begin
                        m_active = 0; e_load = 0; e_err = 1; e_pcw = 0;
                    end
                end else if (m_pos - 2 < 4 * m_n) begin
                    m_word = {m_word[23:0], rx_data};
                    m_chk  = m_chk ^ rx_data;
                    if ((m_pos - 2) % 4 == 3) begin
                        e_we = 1; e_addr = 10'((m_pos - 2) / 4); e_wdata = m_word;
                    end
                end else begin
                    m_active = 0; e_load = 0;
                    if (rx_data == m_chk) begin
                        e_pcc = 1; e_done = 1; e_pcw = 1;
                    end else begin
                        e_err = 1; e_pcw = 0;
                    end
                end
                m_pos++;
            end
        end
    end

    logic [9:0]  log_addr[$];
    logic [31:0] log_data[$];
    int          pcclr_cnt;

    always @(negedge clk) begin
        if (checking) begin
            chk("outputs",
                {16'h0, mem_we, mem_addr, mem_wdata, pc_write, pc_clear, loading, load_done, load_error},
                {16'h0, e_we, e_addr, e_wdata, e_pcw, e_pcc, e_load, e_done, e_err});
            if (mem_we) begin
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
            end
            if (pc_clear) pcclr_cnt++;
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        pcclr_cnt = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_bytes(input logic [7:0] f[$], input int gap_max);
        foreach (f[i]) begin
            send_byte(f[i]);
            idle(int'($urandom_range(0, gap_max)));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [7:0] f[$];
    logic [7:0] nominal[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        checking = 1'b1;
        reset = 1'b0;
        chk("reset_pc_write", 64'(pc_write), 64'd1);
        chk("reset_loading", 64'(loading), 64'd0);
        chk("reset_mem", {31'h0, mem_we, 22'h0, mem_addr}, 64'd0);
        chk("reset_status", {pc_clear, load_done, load_error}, 64'd0);

        // Payload XOR: 20^01^00^05 ^ 8C^02^00^00 = 0xAA.
        nominal = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                    8'h8C, 8'h02, 8'h00, 8'h00, 8'hAA};
        clear_log();
        send_bytes(nominal, 2);
        idle(3);
        chk("nom_writes", 64'(log_addr.size()), 64'd2);
        if (log_addr.size() == 2) begin
            chk("nom_w0", {log_addr[0], log_data[0]}, {10'd0, 32'h20010005});
            chk("nom_w1", {log_addr[1], log_data[1]}, {10'd1, 32'h8C020000});
        end
        chk("nom_pcclr", 64'(pcclr_cnt), 64'd1);
        chk("nom_status", {pc_write, load_done, load_error, loading}, 64'b1100);

        f = nominal;
        f[11] = 8'h00;
        clear_log();
        send_bytes(f, 1);
        idle(3);
        chk("badchk_writes", 64'(log_addr.size()), 64'd2);
        chk("badchk_pcclr", 64'(pcclr_cnt), 64'd0);
        chk("badchk_status", {pc_write, load_done, load_error, loading}, 64'b0010);

        clear_log();
        send_bytes('{8'hA5, 8'h04, 8'h01}, 0);
        idle(6);
        chk("oversize_writes", 64'(log_addr.size()), 64'd0);
        chk("oversize_status", {pc_write, load_done, load_error, loading}, 64'b0010);

        clear_log();
        send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00}, 1);
        idle(3);
        chk("zero_writes", 64'(log_addr.size()), 64'd0);
        chk("zero_pcclr", 64'(pcclr_cnt), 64'd1);
        chk("zero_status", {pc_write, load_done, load_error, loading}, 64'b1100);

        clear_log();
        send_bytes('{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
                     8'hA5, 8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                     8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h01 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF}, 0);
        idle(3);
        chk("b2b_writes", 64'(log_addr.size()), 64'd3);
        if (log_addr.size() == 3) begin
            chk("b2b_w0", {log_addr[0], log_data[0]}, {10'd0, 32'h11223344});
            chk("b2b_w1", {log_addr[1], log_data[1]}, {10'd1, 32'hA5A50001});
            chk("b2b_w2", {log_addr[2], log_data[2]}, {10'd2, 32'hDEADBEEF});
        end
        chk("b2b_done", 64'(load_done), 64'd1);

        send_bytes('{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1);
        do_reset();
        chk("midreset_status", {pc_write, loading, load_done, load_error, mem_we}, 64'b10000);
        clear_log();
        send_bytes(nominal, 0);
        idle(3);
        chk("reload_writes", 64'(log_addr.size()), 64'd2);
        if (log_addr.size() > 0) chk("reload_first_addr", 64'(log_addr[0]), 64'd0);
        chk("reload_done", 64'(load_done), 64'd1);

        // Largest frame that fits: 1024 words.
        begin
            logic [7:0] c;
            c = '0;
            f = '{8'hA5, 8'h04, 8'h00};
            for (int i = 0; i < 4096; i++) begin
                f.push_back(8'($urandom));
                c ^= f[$];
            end
            f.push_back(c);
        end
        clear_log();
        send_bytes(f, 0);
        idle(3);
        chk("max_writes", 64'(log_addr.size()), 64'd1024);
        if (log_addr.size() > 0) chk("max_last_addr", 64'(log_addr[$]), 64'd1023);
        chk("max_done", 64'(load_done), 64'd1);

        for (int fr = 0; fr < 25; fr++) begin
            int n;
            logic [7:0] c;
            int noise;
            f = {};
            noise = int'($urandom_range(0, 2));
            for (int i = 0; i < noise; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                f.push_back(b);
            end
            if ($urandom_range(0, 9) == 0) begin
                n = 1025 + int'($urandom_range(0, 3000));
                f.push_back(8'hA5);
                f.push_back(8'(n >> 8));
                f.push_back(8'(n));
            end else begin
                n = int'($urandom_range(0, 6));
                c = '0;
                f.push_back(8'hA5);
                f.push_back(8'h00);
                f.push_back(8'(n));
                for (int i = 0; i < 4 * n; i++) begin
                    logic [7:0] b;
                    b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
                    f.push_back(b);
                    c ^= b;
                end
                if ($urandom_range(0, 3) == 0) c ^= 8'(1 << $urandom_range(0, 7));
                f.push_back(c);
            end
            send_bytes(f, 2);
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
